// File: rtl/sram_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_controller: 32-bit load/store port onto a 16-bit async SRAM,        |
// | two half-word accesses plus WAIT_CYCLES idle cycles.  Rev 1.0            |
// +--------------------------------------------------------------------------+
module sram_controller #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic [17:0] sram_addr,
   output logic        sram_we_n,
   inout  wire  [15:0] sram_dq
);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_ACC_LO = 3'd1;
   localparam logic [2:0] c_ACC_HI = 3'd2;
   localparam logic [2:0] c_WAIT   = 3'd3;
   localparam logic [2:0] c_DONE   = 3'd4;

   localparam logic [3:0] c_WAIT_LAST = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

   logic [2:0]  state_q,     state_d;
   logic [3:0]  wait_cnt_q,  wait_cnt_d;
   logic        is_wr_q,     is_wr_d;
   logic [31:0] wdata_q,     wdata_d;
   logic [17:0] sram_addr_q, sram_addr_d;
   logic [31:0] rdata_q,     rdata_d;

   logic w_request;
   logic w_drive;
   logic w_unused;

   assign w_request = wr_en | rd_en;
   assign w_unused  = ^{address[31:19], address[1:0]};

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      is_wr_d     = is_wr_q;
      wdata_d     = wdata_q;
      sram_addr_d = sram_addr_q;
      rdata_d     = rdata_q;
      case (state_q)
         c_IDLE: begin
            if (w_request) begin
               state_d     = c_ACC_LO;
               is_wr_d     = wr_en;
               wdata_d     = write_data;
               sram_addr_d = {address[18:2], 1'b0};
            end
         end
         c_ACC_LO: begin
            state_d     = c_ACC_HI;
            sram_addr_d = {sram_addr_q[17:1], 1'b1};
            if (!is_wr_q) begin
               rdata_d[15:0] = sram_dq;
            end
         end
         c_ACC_HI: begin
            if (!is_wr_q) begin
               rdata_d[31:16] = sram_dq;
            end
            if (WAIT_CYCLES > 0) begin
               state_d    = c_WAIT;
               wait_cnt_d = 4'd0;
            end else begin
               state_d = c_DONE;
            end
         end
         c_WAIT: begin
            if (wait_cnt_q == c_WAIT_LAST) begin
               state_d    = c_DONE;
               wait_cnt_d = 4'd0;
            end else begin
               wait_cnt_d = wait_cnt_q + 4'd1;
            end
         end
         c_DONE: begin
            // The request still held here belongs to the access just finished.
            state_d = c_IDLE;
         end
         default: begin
            state_d = c_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= c_IDLE;
         wait_cnt_q  <= 4'd0;
         is_wr_q     <= 1'b0;
         wdata_q     <= 32'd0;
         sram_addr_q <= 18'd0;
         rdata_q     <= 32'd0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         is_wr_q     <= is_wr_d;
         wdata_q     <= wdata_d;
         sram_addr_q <= sram_addr_d;
         rdata_q     <= rdata_d;
      end
   end

   // Reset gates the write strobe immediately so an aborted write stops mid-cycle.
   assign w_drive = is_wr_q && !rst && ((state_q == c_ACC_LO) || (state_q == c_ACC_HI));

   assign sram_we_n = ~w_drive;
   assign sram_dq   = w_drive ? ((state_q == c_ACC_LO) ? wdata_q[15:0] : wdata_q[31:16])
                              : 16'bz;
   assign sram_addr = sram_addr_q;
   assign read_data = rdata_q;
   assign ready     = rst || (state_q == c_DONE) || ((state_q == c_IDLE) && !w_request);

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sram_controller: vectors, corner sequences and random traffic on two  |
// | instances (WAIT_CYCLES=2 and 0), each with its own SRAM model. Rev 1.0   |
// +--------------------------------------------------------------------------+
module tb_sram_controller;

   typedef struct {
      logic        w;
      logic        r;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_rd;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en      [2];
   logic        rd_en      [2];
   logic [31:0] address    [2];
   logic [31:0] write_data [2];
   logic [31:0] read_data  [2];
   logic        ready      [2];
   logic [17:0] sram_addr  [2];
   logic        sram_we_n  [2];
   wire  [15:0] dq0;
   wire  [15:0] dq1;

   logic [15:0] sram0 [262144];
   logic [15:0] sram1 [262144];
   int          wcnt0 = 0;
   int          wcnt1 = 0;

   logic [15:0] exp_mem [int];
   logic [31:0] exp_rd  [2];
   logic [31:0] wlist0 [$];
   logic [31:0] wlist1 [$];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sram_controller #(.WAIT_CYCLES(2)) u_dut_w2 (
      .clk(clk), .rst(rst), .wr_en(wr_en[0]), .rd_en(rd_en[0]), .address(address[0]),
      .write_data(write_data[0]), .read_data(read_data[0]), .ready(ready[0]),
      .sram_addr(sram_addr[0]), .sram_we_n(sram_we_n[0]), .sram_dq(dq0)
   );

   sram_controller #(.WAIT_CYCLES(0)) u_dut_w0 (
      .clk(clk), .rst(rst), .wr_en(wr_en[1]), .rd_en(rd_en[1]), .address(address[1]),
      .write_data(write_data[1]), .read_data(read_data[1]), .ready(ready[1]),
      .sram_addr(sram_addr[1]), .sram_we_n(sram_we_n[1]), .sram_dq(dq1)
   );

   // Asynchronous SRAMs: output enabled whenever not being written.
   assign dq0 = sram_we_n[0] ? sram0[sram_addr[0]] : 16'bz;
   assign dq1 = sram_we_n[1] ? sram1[sram_addr[1]] : 16'bz;

   always @(posedge clk) begin
      if (!sram_we_n[0]) begin
         sram0[sram_addr[0]] <= dq0;
         wcnt0 <= wcnt0 + 1;
      end
   end

   always @(posedge clk) begin
      if (!sram_we_n[1]) begin
         sram1[sram_addr[1]] <= dq1;
         wcnt1 <= wcnt1 + 1;
      end
   end

   function automatic int key(input int s, input logic [17:0] hw);
      return s * (1 << 20) + int'(hw);
   endfunction

   function automatic logic [15:0] exp_get(input int s, input logic [17:0] hw);
      return exp_mem.exists(key(s, hw)) ? exp_mem[key(s, hw)] : 16'h0000;
   endfunction

   function automatic logic [15:0] sram_get(input int s, input logic [17:0] hw);
      return (s == 0) ? sram0[hw] : sram1[hw];
   endfunction

   function automatic int wcnt_get(input int s);
      return (s == 0) ? wcnt0 : wcnt1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Runs one access, leaving the request held through the DONE cycle as a stalled pipeline would.
   task automatic access(input int s, input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input string tag);
      int          low;
      int          wc_start;
      int          exp_low;
      logic [17:0] hw;
      logic [17:0] alo;
      logic [17:0] ahi;
      hw       = {a[18:2], 1'b0};
      exp_low  = 3 + ((s == 0) ? 2 : 0);
      alo      = 18'h0;
      ahi      = 18'h0;
      @(negedge clk);
      wc_start      = wcnt_get(s);
      wr_en[s]      = w;
      rd_en[s]      = r;
      address[s]    = a;
      write_data[s] = d;
      low           = 0;
      #1;
      while (!ready[s] && low < 40) begin
         if (low == 1) alo = sram_addr[s];
         if (low == 2) ahi = sram_addr[s];
         low++;
         @(negedge clk);
         #1;
      end
      if (w) begin
         exp_mem[key(s, hw)]         = d[15:0];
         exp_mem[key(s, hw | 18'h1)] = d[31:16];
      end else if (r) begin
         exp_rd[s] = {exp_get(s, hw | 18'h1), exp_get(s, hw)};
      end
      chk({tag, ".latency"}, low, exp_low);
      chk({tag, ".addr_lo"}, {14'h0, alo}, {14'h0, hw});
      chk({tag, ".addr_hi"}, {14'h0, ahi}, {14'h0, hw | 18'h1});
      chk({tag, ".writes"}, wcnt_get(s) - wc_start, w ? 2 : 0);
      chk({tag, ".read_data"}, read_data[s], exp_rd[s]);
      if (w) begin
         chk({tag, ".sram"}, {sram_get(s, hw | 18'h1), sram_get(s, hw)}, d);
      end
   endtask

   task automatic release_req(input int s, input string tag);
      int wc_start;
      @(negedge clk);
      wc_start = wcnt_get(s);
      wr_en[s] = 1'b0;
      rd_en[s] = 1'b0;
      #1;
      chk({tag, ".idle_ready"}, 32'(ready[s]), 32'd1);
      @(negedge clk);
      #1;
      chk({tag, ".idle_quiet"}, wcnt_get(s) - wc_start + 32'(ready[s]), 32'd1);
   endtask

   vec_t vecs [9];

   initial begin
      int          prev;
      int          s;
      int          op;
      logic [31:0] word;
      logic [31:0] a;
      vecs[0] = '{w: 1'b1, r: 1'b0, a: 32'h0000_0400, d: 32'hDEAD_BEEF, exp_rd: 32'h0000_0000};
      vecs[1] = '{w: 1'b0, r: 1'b1, a: 32'h0000_0400, d: 32'h0,         exp_rd: 32'hDEAD_BEEF};
      vecs[2] = '{w: 1'b1, r: 1'b0, a: 32'h0000_0404, d: 32'h1122_3344, exp_rd: 32'hDEAD_BEEF};
      vecs[3] = '{w: 1'b0, r: 1'b1, a: 32'h0000_0404, d: 32'h0,         exp_rd: 32'h1122_3344};
      vecs[4] = '{w: 1'b1, r: 1'b1, a: 32'h0000_0408, d: 32'hCAFE_F00D, exp_rd: 32'h1122_3344};
      vecs[5] = '{w: 1'b0, r: 1'b1, a: 32'h0000_0408, d: 32'h0,         exp_rd: 32'hCAFE_F00D};
      vecs[6] = '{w: 1'b0, r: 1'b1, a: 32'hFFF8_0407, d: 32'h0,         exp_rd: 32'h1122_3344};
      vecs[7] = '{w: 1'b1, r: 1'b0, a: 32'h0007_FFFC, d: 32'h0BAD_CAFE, exp_rd: 32'h1122_3344};
      vecs[8] = '{w: 1'b0, r: 1'b1, a: 32'hFFFF_FFFF, d: 32'h0,         exp_rd: 32'h0BAD_CAFE};

      for (int i = 0; i < 2; i++) begin
         wr_en[i]      = 1'b0;
         rd_en[i]      = 1'b0;
         address[i]    = 32'h0;
         write_data[i] = 32'h0;
         exp_rd[i]     = 32'h0;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      wr_en[0] = 1'b1;
      #1;
      chk("reset.ready_with_req", 32'(ready[0]), 32'd1);
      chk("reset.we_n", 32'(sram_we_n[0]), 32'd1);
      chk("reset.read_data", read_data[0], 32'h0);
      chk("reset.sram_addr", {14'h0, sram_addr[0]}, 32'h0);
      chk("reset.ready_w0", 32'(ready[1]), 32'd1);
      wr_en[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_reset.ready", 32'(ready[0]), 32'd1);

      for (int i = 0; i < 9; i++) begin
         access(0, vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d.table_rd", i), read_data[0], vecs[i].exp_rd);
      end
      release_req(0, "vec_end");

      // Reset during the high half of a write: the high half-word must survive.
      access(0, 1'b1, 1'b0, 32'h0000_0500, 32'h1234_5678, "pre_abort");
      release_req(0, "pre_abort");
      @(negedge clk);
      wr_en[0]      = 1'b1;
      address[0]    = 32'h0000_0500;
      write_data[0] = 32'hAAAA_BBBB;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("abort.acc_hi_we_n", 32'(sram_we_n[0]), 32'd0);
      chk("abort.acc_hi_addr", {14'h0, sram_addr[0]}, 32'h0000_0281);
      rst = 1'b1;
      #1;
      chk("abort.we_n_released", 32'(sram_we_n[0]), 32'd1);
      @(negedge clk);
      #1;
      chk("abort.ready", 32'(ready[0]), 32'd1);
      chk("abort.we_n", 32'(sram_we_n[0]), 32'd1);
      chk("abort.read_data", read_data[0], 32'h0);
      chk("abort.sram_addr", {14'h0, sram_addr[0]}, 32'h0);
      rst      = 1'b0;
      wr_en[0] = 1'b0;
      exp_rd[0] = 32'h0;
      exp_rd[1] = 32'h0;
      exp_mem[key(0, 18'h280)] = 16'hBBBB;
      #1;
      chk("abort.idle_ready", 32'(ready[0]), 32'd1);
      chk("abort.sram_lo", {16'h0, sram0[18'h280]}, 32'h0000_BBBB);
      chk("abort.sram_hi_kept", {16'h0, sram0[18'h281]}, 32'h0000_1234);
      release_req(0, "abort");

      access(1, 1'b1, 1'b0, 32'h0000_0400, 32'h5555_AAAA, "w0.write");
      access(1, 1'b0, 1'b1, 32'h0000_0400, 32'h0, "w0.read");
      chk("w0.read_value", read_data[1], 32'h5555_AAAA);
      release_req(1, "w0");

      prev = 0;
      for (int i = 0; i < 60; i++) begin
         s  = int'($urandom_range(0, 1));
         op = int'($urandom_range(0, 3));
         if (s != prev || $urandom_range(0, 2) == 0) release_req(prev, "rnd_gap");
         prev = s;
         if (op == 1 && ((s == 0) ? wlist0.size() : wlist1.size()) > 0) begin
            word = (s == 0) ? wlist0[$urandom_range(0, wlist0.size() - 1)]
                            : wlist1[$urandom_range(0, wlist1.size() - 1)];
            a    = ($urandom & 32'hFFF8_0003) | (word << 2);
            access(s, 1'b0, 1'b1, a, $urandom, $sformatf("rnd%0d.rd", i));
         end else begin
            word = 32'h300 + $urandom_range(0, 31);
            a    = ($urandom & 32'hFFF8_0003) | (word << 2);
            if (s == 0) wlist0.push_back(word);
            else        wlist1.push_back(word);
            access(s, 1'b1, (op == 3), a, $urandom, $sformatf("rnd%0d.wr", i));
         end
      end
      release_req(prev, "rnd_end");
      release_req(1 - prev, "rnd_end_other");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
